// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] MUL_OP    = 3'b000;
    localparam logic [2:0] MULH_OP   = 3'b001;
    localparam logic [2:0] MULHSU_OP = 3'b010;
    localparam logic [2:0] MULHU_OP  = 3'b011;
    localparam logic [2:0] DIV_OP    = 3'b100;
    localparam logic [2:0] DIVU_OP   = 3'b101;
    localparam logic [2:0] REM_OP    = 3'b110;
    localparam logic [2:0] REMU_OP   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/muldiv_sign_ctl.sv
// Sign handling for muldiv_unit: operand magnitudes and result-negate flags on
// capture, and the final two's-complement correction on result formation.
module muldiv_sign_ctl
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic              neg_main_in,
    input  logic              neg_rem_in,
    input  logic [2*XLEN-1:0] raw,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              neg_main,
    output logic              neg_rem,
    output logic [2*XLEN-1:0] fixed
);

    logic            signed_a;
    logic            signed_b;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] res_hi;
    logic [XLEN-1:0] res_lo;

    // MUL only needs the low half, which is the same for signed and unsigned.
    always_comb begin
        signed_a = (funct3 == MULH_OP) || (funct3 == MULHSU_OP) ||
                   (funct3 == DIV_OP)  || (funct3 == REM_OP);
        signed_b = (funct3 == MULH_OP) || (funct3 == DIV_OP) || (funct3 == REM_OP);
        neg_a    = signed_a & op_a[XLEN-1];
        neg_b    = signed_b & op_b[XLEN-1];
        mag_a    = neg_a ? -op_a : op_a;
        mag_b    = neg_b ? -op_b : op_b;
        neg_main = neg_a ^ neg_b;
        neg_rem  = neg_a;
        res_hi   = raw[2*XLEN-1:XLEN];
        res_lo   = raw[XLEN-1:0];
        if (funct3[2]) begin
            fixed = {(neg_rem_in ? -res_hi : res_hi), (neg_main_in ? -res_lo : res_lo)};
        end else begin
            fixed = neg_main_in ? -raw : raw;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit writing back to the register file.
// Optional MULDIV_ZERO_BYPASS_EN fast-paths zero multiplies and zero dividends.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg_main_q;
    logic              neg_rem_q;

    logic [XLEN-1:0]   cap_mag_a;
    logic [XLEN-1:0]   cap_mag_b;
    logic              cap_neg_main;
    logic              cap_neg_rem;
    logic [2*XLEN-1:0] res_fixed;
    logic [XLEN-1:0]   result_word;

    logic [2*XLEN-1:0] unused_cap_fixed;
    logic [XLEN-1:0]   unused_res_mag_a;
    logic [XLEN-1:0]   unused_res_mag_b;
    logic              unused_res_neg_main;
    logic              unused_res_neg_rem;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] step_acc;

    logic              fast_hit;
    logic [XLEN-1:0]   fast_val;

    muldiv_sign_ctl #(.XLEN(XLEN)) u_sign_capture (
        .funct3      (funct3),
        .op_a        (rs1_data),
        .op_b        (rs2_data),
        .neg_main_in (1'b0),
        .neg_rem_in  (1'b0),
        .raw         ('0),
        .mag_a       (cap_mag_a),
        .mag_b       (cap_mag_b),
        .neg_main    (cap_neg_main),
        .neg_rem     (cap_neg_rem),
        .fixed       (unused_cap_fixed)
    );

    muldiv_sign_ctl #(.XLEN(XLEN)) u_sign_result (
        .funct3      (op_q),
        .op_a        ('0),
        .op_b        ('0),
        .neg_main_in (neg_main_q),
        .neg_rem_in  (neg_rem_q),
        .raw         (step_acc),
        .mag_a       (unused_res_mag_a),
        .mag_b       (unused_res_mag_b),
        .neg_main    (unused_res_neg_main),
        .neg_rem     (unused_res_neg_rem),
        .fixed       (res_fixed)
    );

    // acc holds the product for multiplies and {remainder, quotient} for divides.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_rem   = XLEN'(div_shift - {1'b0, opnd});
        if (op_q[2]) begin
            step_acc = div_ge ? {div_rem, acc[XLEN-2:0], 1'b1}
                              : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            step_acc = {mul_sum, acc[XLEN-1:1]};
        end
    end

    always_comb begin
        case (op_q)
            MUL_OP, DIV_OP, DIVU_OP: result_word = res_fixed[XLEN-1:0];
            default:                 result_word = res_fixed[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        fast_hit = 1'b0;
        fast_val = '0;
        if (funct3[2]) begin
            if (rs2_data == '0) begin
                fast_hit = 1'b1;
                fast_val = funct3[1] ? rs1_data : '1;
            end else if (!funct3[0] && rs1_data == INT_MIN && rs2_data == '1) begin
                fast_hit = 1'b1;
                fast_val = funct3[1] ? '0 : INT_MIN;
            end
`ifdef MULDIV_ZERO_BYPASS_EN
            else if (rs1_data == '0) begin
                fast_hit = 1'b1;
            end
`endif
        end
`ifdef MULDIV_ZERO_BYPASS_EN
        else if (rs1_data == '0 || rs2_data == '0) begin
            fast_hit = 1'b1;
        end
`endif
    end

    // done/wb_en default low so they only pulse for the single DONE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            opnd       <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
        end else begin
            done  <= 1'b0;
            wb_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        op_q       <= funct3;
                        rd_q       <= rd_addr;
                        neg_main_q <= cap_neg_main;
                        neg_rem_q  <= cap_neg_rem;
                        cnt        <= CNT_W'(XLEN - 1);
                        acc        <= {{XLEN{1'b0}}, (funct3[2] ? cap_mag_a : cap_mag_b)};
                        opnd       <= funct3[2] ? cap_mag_b : cap_mag_a;
                        if (fast_hit) begin
                            wb_data <= fast_val;
                            wb_addr <= rd_addr;
                            done    <= 1'b1;
                            wb_en   <= (rd_addr != 5'd0);
                            state   <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc <= step_acc;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == '0) begin
                            wb_data <= result_word;
                            wb_addr <= rd_q;
                            done    <= 1'b1;
                            wb_en   <= (rd_q != 5'd0);
                            busy    <= 1'b0;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: expected writebacks are queued at
// issue and popped when done pulses.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic        abort    = 1'b0;
    logic [2:0]  funct3   = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_addr  = '0;
    logic        busy;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [4:0]  addr;
        logic        en;
        int          latency;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_data = '0;
    logic [4:0]  last_addr = '0;
    int          stray;

`ifdef MULDIV_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    muldiv_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after the accepting edge.
    task automatic apply_stimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] rd,
                                  input logic [31:0] exp, input int lat, input bit hold);
        start    = 1'b1;
        funct3   = f;
        rs1_data = a;
        rs2_data = b;
        rd_addr  = rd;
        sb.push_back('{tag, exp, rd, (rd != 5'd0), lat});
        @(negedge clk);
        if (!hold) start = 1'b0;
        rs1_data = $urandom;
        rs2_data = $urandom;
        funct3   = 3'($urandom);
        rd_addr  = 5'($urandom);
    endtask

    task automatic check_output();
        exp_t e;
        int   cycles      = 1;
        int   busy_cycles = 0;
        while (done !== 1'b1 && cycles <= 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed=0 entries expected=1");
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_latency"}, 32'(cycles), 32'(e.latency));
        check({e.tag, "_done"}, {31'b0, done}, 32'd1);
        check({e.tag, "_data"}, wb_data, e.data);
        check({e.tag, "_addr"}, {27'b0, wb_addr}, {27'b0, e.addr});
        check({e.tag, "_wb_en"}, {31'b0, wb_en}, {31'b0, e.en});
        check({e.tag, "_busy_cycles"}, 32'(busy_cycles), 32'(e.latency - 1));
        check({e.tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        last_data = e.data;
        last_addr = e.addr;
        @(negedge clk);
        check({e.tag, "_done_pulse"}, {30'b0, done, wb_en}, 32'd0);
        check({e.tag, "_data_hold"}, wb_data, e.data);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_wb_en", {31'b0, wb_en}, 32'd0);
        check("reset_wb_addr", {27'b0, wb_addr}, 32'd0);
        check("reset_wb_data", wb_data, 32'd0);

        apply_stimulus("mul_7_neg3", MUL_OP, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, 1'b0);
        check_output();
        apply_stimulus("mulh_min", MULH_OP, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33, 1'b0);
        check_output();
        apply_stimulus("mulhu_min", MULHU_OP, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 33, 1'b0);
        check_output();
        apply_stimulus("mulhsu_min", MULHSU_OP, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'hC000_0000, 33, 1'b0);
        check_output();
        apply_stimulus("div_neg7_2", DIV_OP, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 33, 1'b0);
        check_output();
        apply_stimulus("rem_neg7_2", REM_OP, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33, 1'b0);
        check_output();
        apply_stimulus("remu_100_7", REMU_OP, 32'd100, 32'd7, 5'd8, 32'd2, 33, 1'b0);
        check_output();
        apply_stimulus("divu_max_1", DIVU_OP, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'hFFFF_FFFF, 33, 1'b0);
        check_output();

        apply_stimulus("div_by_zero", DIV_OP, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1, 1'b0);
        check_output();
        apply_stimulus("rem_by_zero", REM_OP, 32'd5, 32'd0, 5'd14, 32'd5, 1, 1'b0);
        check_output();
        apply_stimulus("div_overflow", DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1, 1'b0);
        check_output();
        apply_stimulus("rem_overflow", REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1, 1'b0);
        check_output();

        apply_stimulus("mul_zero", MUL_OP, 32'd0, 32'h0000_1234, 5'd17, 32'd0, ZERO_LAT, 1'b0);
        check_output();
        apply_stimulus("divu_zero_dividend", DIVU_OP, 32'd0, 32'd5, 5'd18, 32'd0, ZERO_LAT, 1'b0);
        check_output();

        // Abort in cycle 10 of CALC; the aborted op is never queued.
        start    = 1'b1;
        funct3   = MUL_OP;
        rs1_data = 32'd16;
        rs2_data = 32'd16;
        rd_addr  = 5'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy_after", {31'b0, busy}, 32'd0);
        check("abort_no_done", {30'b0, done, wb_en}, 32'd0);
        check("abort_data_kept", wb_data, last_data);
        check("abort_addr_kept", {27'b0, wb_addr}, {27'b0, last_addr});
        apply_stimulus("after_abort", MUL_OP, 32'd16, 32'd16, 5'd12, 32'h0000_0100, 33, 1'b0);
        check_output();

        apply_stimulus("rd_zero", DIVU_OP, 32'd50, 32'd5, 5'd0, 32'd10, 33, 1'b0);
        check_output();

        apply_stimulus("held_start", MULHU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 33, 1'b1);
        check_output();
        stray = 0;
        repeat (40) begin
            if (done === 1'b1 || busy === 1'b1) stray++;
            @(negedge clk);
        end
        check("held_start_single", 32'(stray), 32'd0);

        // Reset in cycle 15 of CALC clears everything without a writeback.
        start    = 1'b1;
        funct3   = MUL_OP;
        rs1_data = 32'd3;
        rs2_data = 32'd3;
        rd_addr  = 5'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        check("rst_mid_wb_en", {31'b0, wb_en}, 32'd0);
        check("rst_mid_wb_addr", {27'b0, wb_addr}, 32'd0);
        check("rst_mid_wb_data", wb_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        stray = 0;
        repeat (40) begin
            if (done === 1'b1 || wb_en === 1'b1 || busy === 1'b1) stray++;
            @(negedge clk);
        end
        check("rst_mid_no_writeback", 32'(stray), 32'd0);
        check("rst_mid_data_after", wb_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
